// File: rtl/nf_pkg.sv
// Shared constants and bit-index helper for the NullFresh compression stage.
package nf_pkg;
    localparam int NF_NCOMP  = 18;
    localparam int NF_NSHARE = 3;
    localparam int NF_GROUP  = 6;

    // Flat bit position of component k of coordinate j in the comp_i bus.
    function automatic int nf_comp_idx(input int j, input int k);
        return j * NF_NCOMP + k;
    endfunction
endpackage

// File: rtl/nf_xor6.sv
// Six-input XOR that folds one group of components into one share bit.
module nf_xor6
    import nf_pkg::*;
(
    input  logic [NF_GROUP-1:0] d_i,
    output logic                y_o
);
    assign y_o = ^d_i;
endmodule

// File: rtl/nf_compress_stage.sv
// Glitch-barrier register, 6:1 XOR compression into three shares, output register.
module nf_compress_stage
    import nf_pkg::*;
#(
    parameter int NCOORD = 4,
    parameter int NCOMP  = NF_NCOMP
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCOORD*NCOMP-1:0] comp_i,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    clear,
    output logic [NCOORD-1:0]       share1_o,
    output logic [NCOORD-1:0]       share2_o,
    output logic [NCOORD-1:0]       share3_o,
    output logic                    out_valid,
    input  logic                    out_ready
);
    logic [NCOORD*NCOMP-1:0]              s1_data_q, s1_data_d;
    logic                                 s1_valid_q, s1_valid_d;
    logic [NF_NSHARE-1:0][NCOORD-1:0]     s2_share_q, s2_share_d;
    logic                                 s2_valid_q, s2_valid_d;
    logic [NF_NSHARE-1:0][NCOORD-1:0]     comp_share;
    logic                                 s1_adv, s2_adv, s1_load, s2_load;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign s1_load  = in_valid && s1_adv;
    assign s2_load  = s1_valid_q && s2_adv;

    // Compression reads only the S1 register, never comp_i directly.
    for (genvar j = 0; j < NCOORD; j++) begin : g_coord
        for (genvar s = 0; s < NF_NSHARE; s++) begin : g_share
            localparam int BASE = nf_comp_idx(j, s * NF_GROUP);
            nf_xor6 u_xor6 (
                .d_i (s1_data_q[BASE +: NF_GROUP]),
                .y_o (comp_share[s][j])
            );
        end
    end

    always_comb begin
        s1_data_d  = s1_load ? comp_i : s1_data_q;
        s1_valid_d = s1_load ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
        s2_share_d = s2_load ? comp_share : s2_share_q;
        s2_valid_d = s2_load ? 1'b1 : (out_ready ? 1'b0 : s2_valid_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
            s2_share_q <= '0;
            s2_valid_q <= 1'b0;
        end else if (clear) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
            s2_share_q <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
            s2_share_q <= s2_share_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    assign share1_o  = s2_share_q[0];
    assign share2_o  = s2_share_q[1];
    assign share3_o  = s2_share_q[2];
    assign out_valid = s2_valid_q;
endmodule

// File: doc/nf_compress_stage.md
# nf_compress_stage

Pipelined register-and-compression stage that follows the second-order, three-share NullFresh component-function layer of the masked PRINCE S-box. It captures all 18 component-function outputs for each of `NCOORD` coordinate functions in a glitch-barrier register. It then XOR-compresses each group of six components into one of three output shares and registers the result. Valid/ready handshakes on both sides let it stall under the round controller.

## Interface
Parameters:
- `NCOORD`, default 4: number of coordinate functions (S-box output bits).
- `NCOMP`, default 18: component functions per coordinate; fixed at 18, other values unsupported.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `comp_i`, in, NCOORD*NCOMP: component outputs. Bit `j*NCOMP+k` is component `k` (num=k) of coordinate `j`.
- `in_valid`, in, 1: `comp_i` holds a valid set this cycle.
- `in_ready`, out, 1: stage accepts `comp_i` this cycle.
- `clear`, in, 1: synchronous zeroization of all data and valid registers.
- `share1_o`, `share2_o`, `share3_o`, out, NCOORD each: three output shares, bit `j` belonging to coordinate `j`.
- `out_valid`, out, 1: shares are valid.
- `out_ready`, in, 1: consumer accepts shares.

## Operation
- Stage 1 (S1) stores 72 component bits plus `s1_valid`. It is a register barrier: no combinational path runs from `comp_i` to any compression XOR.
- Compression for coordinate `j`:
  - `share1[j]` = XOR of components 0–5.
  - `share2[j]` = XOR of components 6–11.
  - `share3[j]` = XOR of components 12–17.
- The compression is computed from S1 contents only.
- Stage 2 (S2) stores the three share vectors plus `s2_valid`. Outputs are driven directly from S2.
- Advance rules:
  - `s2_adv = !s2_valid || out_ready`.
  - `s1_adv = !s1_valid || s2_adv`.
  - `in_ready = s1_adv`.
- Transfer conditions:
  - S1 loads when `in_valid && in_ready`.
  - S2 loads S1's compression when `s1_valid && s2_adv`.
- S1 to S2 hand-off:
  - S1 holds its data when stalled.
  - When S2 takes S1's data and no new input arrives, `s1_valid` clears.
  - S1's data bits are then left unchanged; they are not zeroed, to avoid extra toggling.
- S2 clearing: `s2_valid` clears when `out_valid && out_ready` and S1 is empty.
- Register updates: data registers update only on load. No enable-free toggling.
- `clear` has priority over all loads and sets every register to 0 on the next edge.
- Mid-operation `rst_n` assertion zeroes everything immediately, independent of clock.

## Timing
- Reset values: `share1_o`/`share2_o`/`share3_o` = 0, `out_valid` = 0, `in_ready` = 1. All internal registers = 0.
- Latency: an input accepted at edge t appears with `out_valid` = 1 after edge t+1 (two registers), when unstalled.
- Throughput: one set per cycle with `out_ready` held high.
- Backpressure: with `out_ready` = 0, the pipeline absorbs exactly two sets and then drops `in_ready`. `in_ready` depends combinationally on `out_ready`.
- Simultaneous full-pipeline accept and output drain in the same cycle: both transfers occur and no data is lost or duplicated.
- `clear` together with `in_valid`: the input is discarded, even though `in_ready` was 1.
- Boundary: `out_valid` stays high, with stable shares, until accepted.

## Structure
- Package `nf_pkg`:
  - `NF_NCOMP` = 18.
  - `NF_NSHARE` = 3.
  - `NF_GROUP` = 6.
  - Function `nf_comp_idx(j,k)`.
- Sub-module `nf_xor6`: combinational 6-input XOR, instantiated `NCOORD*3` times.
- No other hierarchy.

## Test plan
- Reset then idle: after `rst_n` low, `in_ready` = 1, `out_valid` = 0, all shares = 0.
- Single set, coordinate 0 with comps 0–17 = `18'b000001_000011_000111`, others 0:
  - Accepted at cycle 1.
  - At cycle 3 `out_valid` = 1 with `share1_o` = 4'b0001, `share2_o` = 4'b0000, `share3_o` = 4'b0001.
- Streaming 8 random sets with `out_ready` = 1:
  - One output per cycle.
  - The XOR of the three shares per bit equals the XOR of all 18 reference components.
- Backpressure:
  - `out_ready` = 0 for 4 cycles while `in_valid` = 1.
  - `in_ready` falls after 2 accepts.
  - On release, outputs emerge in order with no loss or duplication.
- Clear with full pipeline: `clear` pulse → next cycle `out_valid` = 0, shares = 0, `in_ready` = 1.
- Asynchronous reset mid-stall: `rst_n` low between edges → outputs zero immediately. Post-release behaviour matches the reset scenario.
